// File: rtl/dma_arb_pkg.sv
// Shared types and helpers for the multi-port DMA request arbiter.
package dma_arb_pkg;

   // Transaction sequencing: grant, kick the DMA, move beats, wait for done, respond.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      GO        = 3'd1,
      XFER      = 3'd2,
      WAIT_DONE = 3'd3,
      RESP      = 3'd4
   } state_t;

   // Widths for the default configuration (4 ports, 4 segments).
   localparam int DEF_NUM_PORTS = 4;
   localparam int DEF_NUM_SEGS  = 4;
   localparam int SEG_BITS      = $clog2(DEF_NUM_SEGS);
   localparam int PORT_IDX_BITS = $clog2(DEF_NUM_PORTS);

   // Segment number held in the top seg_bits bits of an addr_width-bit address.
   // The address is passed zero-extended to 64 bits so one helper serves any width.
   function automatic int unsigned seg_of(input logic [63:0] addr,
                                          input int unsigned addr_width,
                                          input int unsigned seg_bits);
      logic [63:0] s;
      s = '0;
      if (seg_bits == 0) begin
         return 0;
      end
      s = addr >> (addr_width - seg_bits);
      s = s & ((64'd1 << seg_bits) - 64'd1);
      return 32'(s);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting port at or after ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter int IDX_W     = $clog2(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     ptr,
   output logic [NUM_PORTS-1:0] grant,
   output logic [IDX_W-1:0]     grant_idx,
   output logic                 any_req
);

   // Position in the rotation, one extra bit so ptr+i cannot overflow before the wrap.
   logic [IDX_W:0] pos;

   // Scan the rotation starting at ptr and keep only the first hit.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_req   = 1'b0;
      pos       = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         pos = {1'b0, ptr} + (IDX_W+1)'(i);
         if (pos >= (IDX_W+1)'(NUM_PORTS)) begin
            pos = pos - (IDX_W+1)'(NUM_PORTS);
         end
         if (!any_req && req[pos[IDX_W-1:0]]) begin
            any_req                 = 1'b1;
            grant[pos[IDX_W-1:0]]   = 1'b1;
            grant_idx               = pos[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/dma_req_arbiter.sv
// Round-robin arbiter steering NUM_PORTS cacheline requesters onto one DMA
// read/write channel pair, with segmented address translation and burst steering.
module dma_req_arbiter
   import dma_arb_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int NUM_SEGS   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 512,
   parameter int LEN_WIDTH  = 4,
   parameter int SIZE_WIDTH = 17
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_SEGS*ADDR_WIDTH-1:0]   seg_base,
   input  logic [NUM_PORTS-1:0]             req_valid,
   input  logic [NUM_PORTS-1:0]             req_we,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_PORTS*LEN_WIDTH-1:0]   req_len,
   output logic [NUM_PORTS-1:0]             req_ready,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata,
   output logic [NUM_PORTS-1:0]             wdata_pop,
   output logic [DATA_WIDTH-1:0]            rdata,
   output logic [NUM_PORTS-1:0]             rdata_valid,
   output logic [NUM_PORTS-1:0]             resp_done,
   output logic                             busy,
   output logic [ADDR_WIDTH-1:0]            dma_rd_addr,
   output logic [ADDR_WIDTH-1:0]            dma_wr_addr,
   output logic [SIZE_WIDTH-1:0]            dma_rd_size,
   output logic [SIZE_WIDTH-1:0]            dma_wr_size,
   output logic                             dma_rd_go,
   output logic                             dma_wr_go,
   output logic                             dma_rd_en,
   input  logic [DATA_WIDTH-1:0]            dma_rd_data,
   input  logic                             dma_empty,
   input  logic                             dma_rd_done,
   output logic                             dma_wr_en,
   output logic [DATA_WIDTH-1:0]            dma_wr_data,
   input  logic                             dma_full,
   input  logic                             dma_wr_done
);

   localparam int IDX_W      = $clog2(NUM_PORTS);
   localparam int SEG_BITS_P = $clog2(NUM_SEGS);
   localparam int SEG_W      = (NUM_SEGS > 1) ? SEG_BITS_P : 1;
   // Keeps the in-segment offset, clearing the segment-select bits.
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = {ADDR_WIDTH{1'b1}} >> SEG_BITS_P;

   // Unpacked views of the flat port buses.
   logic [ADDR_WIDTH-1:0] addr_arr     [NUM_PORTS];
   logic [LEN_WIDTH-1:0]  len_arr      [NUM_PORTS];
   logic [DATA_WIDTH-1:0] wdata_arr    [NUM_PORTS];
   logic [ADDR_WIDTH-1:0] seg_base_arr [NUM_SEGS];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port_unpack
         assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign len_arr[gi]   = req_len[gi*LEN_WIDTH +: LEN_WIDTH];
         assign wdata_arr[gi] = port_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
      end
      for (gi = 0; gi < NUM_SEGS; gi++) begin : g_seg_unpack
         assign seg_base_arr[gi] = seg_base[gi*ADDR_WIDTH +: ADDR_WIDTH];
      end
   endgenerate

   // Latched transaction context.
   state_t                state_reg, state_next;
   logic [IDX_W-1:0]      ptr_reg,   ptr_next;
   logic [IDX_W-1:0]      g_reg,     g_next;
   logic                  we_reg,    we_next;
   logic [LEN_WIDTH-1:0]  len_reg,   len_next;
   logic [LEN_WIDTH-1:0]  cnt_reg,   cnt_next;
   logic [ADDR_WIDTH-1:0] addr_reg,  addr_next;

   logic [NUM_PORTS-1:0]  grant;
   logic [IDX_W-1:0]      grant_idx;
   logic                  any_req;

   rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_rr (
      .req       (req_valid),
      .ptr       (ptr_reg),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   // Translation of the candidate port's address; only latched on grant.
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [SEG_W-1:0]      sel_seg;
   logic [ADDR_WIDTH-1:0] phys_addr;

   assign sel_addr  = addr_arr[grant_idx];
   assign sel_seg   = SEG_W'(seg_of(64'(sel_addr), ADDR_WIDTH, SEG_BITS_P));
   assign phys_addr = seg_base_arr[sel_seg] + (sel_addr & OFF_MASK);

   // State and context registers; reset drops any in-flight transfer silently.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         g_reg     <= '0;
         we_reg    <= 1'b0;
         len_reg   <= '0;
         cnt_reg   <= '0;
         addr_reg  <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         g_reg     <= g_next;
         we_reg    <= we_next;
         len_reg   <= len_next;
         cnt_reg   <= cnt_next;
         addr_reg  <= addr_next;
      end
   end

   // Next-state logic plus all per-cycle pulses and data steering.
   always_comb begin
      state_next  = state_reg;
      ptr_next    = ptr_reg;
      g_next      = g_reg;
      we_next     = we_reg;
      len_next    = len_reg;
      cnt_next    = cnt_reg;
      addr_next   = addr_reg;
      req_ready   = '0;
      wdata_pop   = '0;
      rdata_valid = '0;
      resp_done   = '0;
      rdata       = '0;
      dma_wr_data = '0;
      dma_rd_go   = 1'b0;
      dma_wr_go   = 1'b0;
      dma_rd_en   = 1'b0;
      dma_wr_en   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (any_req && !rst) begin
               req_ready  = grant;
               g_next     = grant_idx;
               we_next    = req_we[grant_idx];
               len_next   = len_arr[grant_idx];
               addr_next  = phys_addr;
               cnt_next   = '0;
               state_next = GO;
            end
         end
         GO: begin
            dma_rd_go  = !we_reg;
            dma_wr_go  = we_reg;
            state_next = XFER;
         end
         XFER: begin
            if (we_reg ? !dma_full : !dma_empty) begin
               if (we_reg) begin
                  dma_wr_en        = 1'b1;
                  dma_wr_data      = wdata_arr[g_reg];
                  wdata_pop[g_reg] = 1'b1;
               end else begin
                  dma_rd_en          = 1'b1;
                  rdata              = dma_rd_data;
                  rdata_valid[g_reg] = 1'b1;
               end
               // The beat that reaches len is the last; stop before an extra one.
               if (cnt_reg == len_reg) begin
                  cnt_next   = '0;
                  state_next = WAIT_DONE;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         WAIT_DONE: begin
            if (we_reg ? dma_wr_done : dma_rd_done) begin
               state_next = RESP;
            end
         end
         RESP: begin
            resp_done[g_reg] = 1'b1;
            ptr_next   = (g_reg == IDX_W'(NUM_PORTS-1)) ? '0 : g_reg + 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Address and size are held for the whole transaction on the active direction only.
   assign busy        = (state_reg != IDLE);
   assign dma_rd_addr = (busy && !we_reg) ? addr_reg : '0;
   assign dma_wr_addr = (busy &&  we_reg) ? addr_reg : '0;
   assign dma_rd_size = (busy && !we_reg) ? SIZE_WIDTH'(len_reg) + SIZE_WIDTH'(1) : '0;
   assign dma_wr_size = (busy &&  we_reg) ? SIZE_WIDTH'(len_reg) + SIZE_WIDTH'(1) : '0;

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Directed bench for dma_req_arbiter: read, backpressured write burst, reset abort,
// slow done, round-robin fairness and address wrap.
module tb_dma_req_arbiter;

   localparam int NP = 4;
   localparam int NS = 4;
   localparam int AW = 32;
   localparam int DW = 64;
   localparam int LW = 4;
   localparam int SW = 17;

   logic              clk = 1'b0;
   logic              rst;
   logic [NS*AW-1:0]  seg_base;
   logic [NP-1:0]     req_valid, req_we, req_ready, wdata_pop, rdata_valid, resp_done;
   logic [NP*AW-1:0]  req_addr;
   logic [NP*LW-1:0]  req_len;
   logic [NP*DW-1:0]  port_wdata;
   logic [DW-1:0]     rdata, dma_rd_data, dma_wr_data;
   logic              busy, dma_rd_go, dma_wr_go, dma_rd_en, dma_wr_en;
   logic [AW-1:0]     dma_rd_addr, dma_wr_addr;
   logic [SW-1:0]     dma_rd_size, dma_wr_size;
   logic              dma_empty, dma_rd_done, dma_full, dma_wr_done;

   always #5 clk = ~clk;

   dma_req_arbiter #(
      .NUM_PORTS(NP), .NUM_SEGS(NS), .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW), .LEN_WIDTH(LW), .SIZE_WIDTH(SW)
   ) dut (
      .clk(clk), .rst(rst), .seg_base(seg_base),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_len(req_len),
      .req_ready(req_ready), .port_wdata(port_wdata), .wdata_pop(wdata_pop),
      .rdata(rdata), .rdata_valid(rdata_valid), .resp_done(resp_done), .busy(busy),
      .dma_rd_addr(dma_rd_addr), .dma_wr_addr(dma_wr_addr),
      .dma_rd_size(dma_rd_size), .dma_wr_size(dma_wr_size),
      .dma_rd_go(dma_rd_go), .dma_wr_go(dma_wr_go), .dma_rd_en(dma_rd_en),
      .dma_rd_data(dma_rd_data), .dma_empty(dma_empty), .dma_rd_done(dma_rd_done),
      .dma_wr_en(dma_wr_en), .dma_wr_data(dma_wr_data), .dma_full(dma_full),
      .dma_wr_done(dma_wr_done)
   );

   int tests  = 0;
   int failed = 0;

   // Event tallies gathered at each active edge.
   int cyc = 0;
   int rd_go_n = 0, wr_go_n = 0, rd_en_n = 0, wr_en_n = 0;
   int wr_full_viol = 0, wr_data_bad = 0, rd_data_bad = 0;
   int rvalid_n [NP];
   int pop_n    [NP];
   int done_n   [NP];
   int grant_q  [$];
   int grant_t  [$];
   logic [AW-1:0] go_addr;
   logic [SW-1:0] go_size;

   initial begin
      for (int k = 0; k < NP; k++) begin
         rvalid_n[k] = 0;
         pop_n[k]    = 0;
         done_n[k]   = 0;
      end
   end

   always @(posedge clk) begin
      cyc++;
      if (!rst) begin
         if (dma_rd_go) begin rd_go_n++; go_addr = dma_rd_addr; go_size = dma_rd_size; end
         if (dma_wr_go) begin wr_go_n++; go_addr = dma_wr_addr; go_size = dma_wr_size; end
         if (dma_rd_en) begin
            rd_en_n++;
            if (rdata !== dma_rd_data) rd_data_bad++;
         end
         if (dma_wr_en) begin
            wr_en_n++;
            if (dma_full) wr_full_viol++;
         end
         for (int k = 0; k < NP; k++) begin
            if (rdata_valid[k]) rvalid_n[k]++;
            if (wdata_pop[k]) begin
               pop_n[k]++;
               if (dma_wr_data !== port_wdata[k*DW +: DW]) wr_data_bad++;
            end
            if (resp_done[k]) done_n[k]++;
            if (req_ready[k]) begin grant_q.push_back(k); grant_t.push_back(cyc); end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      if (busy) begin
         tests++;
         failed++;
         $error("FAIL %s timeout busy=%0b expected=0", tag, busy);
      end
   endtask

   int b_go, b_en, b_rv, b_done, b_pop, bq, bad;
   logic seen;
   int exp_order [5] = '{0, 1, 2, 3, 0};

   initial begin
      rst = 1'b1;
      seg_base = {32'hFFFF_FFC0, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
      req_valid = '0; req_we = '0; req_addr = '0; req_len = '0; port_wdata = '0;
      dma_rd_data = 64'hDEAD_BEEF_0000_0001;
      dma_empty = 1'b0; dma_rd_done = 1'b0; dma_full = 1'b0; dma_wr_done = 1'b0;
      repeat (3) tick();
      #4;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_rd_en", 64'(dma_rd_en), 64'd0);
      check("reset_rd_addr", 64'(dma_rd_addr), 64'd0);
      tick();
      rst = 1'b0;
      tick();

      // ---- single read, port1, seg1 ----
      req_addr[1*AW +: AW] = 32'h4000_0040;
      req_len[1*LW +: LW]  = 4'd0;
      req_valid = 4'b0010;
      b_go = rd_go_n; b_rv = rvalid_n[1]; b_done = done_n[1];
      #4 check("t1_ready", 64'(req_ready), 64'b0010);
      tick(); req_valid = '0;
      #4 check("t1_go", 64'(dma_rd_go), 64'd1);
      check("t1_addr", 64'(dma_rd_addr), 64'h1000_0040);
      check("t1_size", 64'(dma_rd_size), 64'd1);
      tick();
      #4 check("t1_rvalid", 64'(rdata_valid), 64'b0010);
      check("t1_rdata", rdata, 64'hDEAD_BEEF_0000_0001);
      tick();
      #4 check("t1_no_extra_beat", 64'(dma_rd_en), 64'd0);
      check("t1_no_early_done", 64'(resp_done), 64'd0);
      dma_rd_done = 1'b1;
      tick(); dma_rd_done = 1'b0;
      #4 check("t1_resp", 64'(resp_done), 64'b0010);
      tick();
      #4 check("t1_idle", 64'(busy), 64'd0);
      check("t1_go_count", 64'(rd_go_n - b_go), 64'd1);
      check("t1_rvalid_count", 64'(rvalid_n[1] - b_rv), 64'd1);
      check("t1_done_count", 64'(done_n[1] - b_done), 64'd1);
      tick();

      // ---- write burst len=3 on port0 with dma_full toggling ----
      req_we = 4'b0001;
      req_addr[0 +: AW] = 32'h0000_0200;
      req_len[0 +: LW] = 4'd3;
      port_wdata[0 +: DW] = 64'hA5A5_0000_1111_2222;
      b_go = wr_go_n; b_en = wr_en_n; b_pop = pop_n[0]; b_done = done_n[0];
      bq = grant_q.size();
      req_valid = 4'b0001;
      seen = 1'b0;
      for (int c = 0; c < 80 && !seen; c++) begin
         tick();
         dma_full = ~dma_full;
         if (grant_q.size() > bq) req_valid = '0;
         if (wr_en_n - b_en >= 4) dma_wr_done = 1'b1;
         if (done_n[0] != b_done) seen = 1'b1;
      end
      if (!seen) begin
         tests++; failed++;
         $error("FAIL t2_timeout resp_done=0 expected=1");
      end
      dma_full = 1'b0; dma_wr_done = 1'b0;
      check("t2_wr_en_count", 64'(wr_en_n - b_en), 64'd4);
      check("t2_pop_count", 64'(pop_n[0] - b_pop), 64'd4);
      check("t2_en_while_full", 64'(wr_full_viol), 64'd0);
      check("t2_wdata", 64'(wr_data_bad), 64'd0);
      check("t2_size", 64'(go_size), 64'd4);
      check("t2_addr", 64'(go_addr), 64'h0000_0200);
      check("t2_go_count", 64'(wr_go_n - b_go), 64'd1);
      check("t2_done_count", 64'(done_n[0] - b_done), 64'd1);
      wait_idle("t2_idle");
      req_we = '0;
      tick();

      // ---- reset in the middle of a 4-beat read ----
      req_addr[0 +: AW] = 32'h0000_1000;
      req_len[0 +: LW] = 4'd3;
      b_go = rd_go_n; b_en = rd_en_n; b_done = done_n[0];
      req_valid = 4'b0001;
      #4 check("t6_ready", 64'(req_ready), 64'b0001);
      tick(); req_valid = '0;
      tick();
      #4 check("t6_beat1", 64'(dma_rd_en), 64'd1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #4 check("t6_busy", 64'(busy), 64'd0);
      check("t6_rd_en", 64'(dma_rd_en), 64'd0);
      check("t6_rvalid", 64'(rdata_valid), 64'd0);
      check("t6_rd_addr", 64'(dma_rd_addr), 64'd0);
      check("t6_rd_size", 64'(dma_rd_size), 64'd0);
      check("t6_rdata", rdata, 64'd0);
      repeat (10) tick();
      check("t6_no_done", 64'(done_n[0] - b_done), 64'd0);
      check("t6_no_rego", 64'(rd_go_n - b_go), 64'd1);
      // With the pointer back at 0, port0 wins over port3.
      req_addr[3*AW +: AW] = 32'h0000_0300;
      req_len[0 +: LW] = 4'd0;
      req_len[3*LW +: LW] = 4'd0;
      req_valid = 4'b1001;
      #4 check("t6_ptr_zero", 64'(req_ready), 64'b0001);
      tick(); req_valid = '0;
      dma_rd_done = 1'b1;
      wait_idle("t6_idle");
      dma_rd_done = 1'b0;
      check("t6_served", 64'(done_n[0] - b_done), 64'd1);
      tick();

      // ---- slow done: port3, seg2, len=1 ----
      req_addr[3*AW +: AW] = 32'h8000_0100;
      req_len[3*LW +: LW] = 4'd1;
      b_en = rd_en_n; b_done = done_n[3];
      req_valid = 4'b1000;
      #4 check("t5_ready", 64'(req_ready), 64'b1000);
      tick(); req_valid = '0;
      #4 check("t5_addr", 64'(dma_rd_addr), 64'h2000_0100);
      check("t5_size", 64'(dma_rd_size), 64'd2);
      tick(); tick(); tick();
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         #4 if (!busy || resp_done != '0 || dma_rd_en) bad++;
         tick();
      end
      check("t5_held_wait", 64'(bad), 64'd0);
      check("t5_beats", 64'(rd_en_n - b_en), 64'd2);
      dma_rd_done = 1'b1;
      #4 check("t5_not_yet", 64'(resp_done), 64'd0);
      tick(); dma_rd_done = 1'b0;
      #4 check("t5_resp", 64'(resp_done), 64'b1000);
      wait_idle("t5_idle");
      tick();

      // ---- fairness: all ports valid, pointer starts at 0 ----
      for (int k = 0; k < NP; k++) begin
         req_addr[k*AW +: AW] = 32'h0000_0400 + 32'(k);
         req_len[k*LW +: LW]  = 4'd0;
      end
      dma_rd_done = 1'b1;
      bq = grant_q.size();
      req_valid = 4'b1111;
      for (int c = 0; c < 100 && (grant_q.size() - bq) < 5; c++) tick();
      req_valid = '0;
      if (grant_q.size() - bq < 5) begin
         tests++; failed++;
         $error("FAIL t3_timeout grants=%0d expected=5", grant_q.size() - bq);
      end else begin
         for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_grant%0d", i), 64'(grant_q[bq+i]), 64'(exp_order[i]));
         end
         check("t3_gap", 64'(grant_t[bq+1] - grant_t[bq]), 64'd5);
      end
      wait_idle("t3_idle");
      dma_rd_done = 1'b0;
      tick();

      // ---- address wrap: seg3 base 0xFFFF_FFC0 + offset 0x80 ----
      req_addr[2*AW +: AW] = 32'hC000_0080;
      b_done = done_n[2];
      req_valid = 4'b0100;
      #4 check("t4_ready", 64'(req_ready), 64'b0100);
      tick(); req_valid = '0;
      #4 check("t4_addr", 64'(dma_rd_addr), 64'h0000_0040);
      check("t4_go", 64'(dma_rd_go), 64'd1);
      dma_rd_done = 1'b1;
      wait_idle("t4_idle");
      dma_rd_done = 1'b0;
      check("t4_done", 64'(done_n[2] - b_done), 64'd1);
      check("rd_data_steer", 64'(rd_data_bad), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
